// File: rtl/midi_tx.sv
// MIDI serial transmitter: frames a 2- or 3-byte channel message as 8N1 UART bytes,
// with optional running-status suppression of a repeated status byte.
module midi_tx #(
    parameter int unsigned BAUD_DIV       = 320,
    parameter bit          RUNNING_STATUS = 1'b1
) (
    input  logic       MHz10,
    input  logic       rst,
    input  logic       en,
    input  logic       clear,
    input  logic       send,
    input  logic [7:0] status,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    output logic       serOut,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CntW-1:0] BaudMax = CntW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      cur_q, cur_d;
    logic [7:0]      nxt0_q, nxt0_d;
    logic [7:0]      nxt1_q, nxt1_d;
    logic [1:0]      left_q, left_d;
    logic            cur_is_st_q, cur_is_st_d;
    logic [7:0]      rs_q, rs_d;
    logic            rs_vld_q, rs_vld_d;
    logic            ser_q, ser_d;
    logic            err_q, err_d;

    logic       baud_end;
    logic       abort;
    logic       st_ok;
    logic       two_byte;
    logic       skip_st;
    logic [2:0] nbit;

    assign baud_end = (baud_cnt_q == BaudMax);
    assign abort    = !en || clear;
    assign st_ok    = status[7] && (status[7:4] != 4'hF);
    assign two_byte = (status[7:4] == 4'hC) || (status[7:4] == 4'hD);
    assign skip_st  = RUNNING_STATUS && rs_vld_q && (rs_q == status);
    assign nbit     = bit_cnt_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        cur_d       = cur_q;
        nxt0_d      = nxt0_q;
        nxt1_d      = nxt1_q;
        left_d      = left_q;
        cur_is_st_d = cur_is_st_q;
        rs_d        = rs_q;
        rs_vld_d    = rs_vld_q;
        ser_d       = ser_q;
        err_d       = 1'b0;

        if (abort) begin
            state_d     = StIdle;
            baud_cnt_d  = '0;
            bit_cnt_d   = '0;
            left_d      = '0;
            cur_is_st_d = 1'b0;
            rs_vld_d    = 1'b0;
            ser_d       = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ser_d = 1'b1;
                    if (send) begin
                        if (!st_ok) begin
                            err_d = 1'b1;
                        end else begin
                            // Queue the bytes to go out after the first one.
                            if (skip_st) begin
                                cur_d       = {1'b0, data1[6:0]};
                                nxt0_d      = {1'b0, data2[6:0]};
                                left_d      = two_byte ? 2'd0 : 2'd1;
                                cur_is_st_d = 1'b0;
                            end else begin
                                cur_d       = status;
                                nxt0_d      = {1'b0, data1[6:0]};
                                nxt1_d      = {1'b0, data2[6:0]};
                                left_d      = two_byte ? 2'd1 : 2'd2;
                                cur_is_st_d = 1'b1;
                            end
                            state_d    = StStart;
                            baud_cnt_d = '0;
                            bit_cnt_d  = '0;
                            ser_d      = 1'b0;
                        end
                    end
                end
                StStart: begin
                    if (baud_end) begin
                        baud_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = StData;
                        ser_d      = cur_q[0];
                    end else begin
                        baud_cnt_d = baud_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud_cnt_d = '0;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StStop;
                            ser_d   = 1'b1;
                        end else begin
                            bit_cnt_d = nbit;
                            ser_d     = cur_q[nbit];
                        end
                    end else begin
                        baud_cnt_d = baud_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud_cnt_d = '0;
                        if (cur_is_st_q) begin
                            rs_d     = cur_q;
                            rs_vld_d = 1'b1;
                        end
                        cur_is_st_d = 1'b0;
                        if (left_q != 2'd0) begin
                            cur_d   = nxt0_q;
                            nxt0_d  = nxt1_q;
                            left_d  = left_q - 2'd1;
                            state_d = StStart;
                            ser_d   = 1'b0;
                        end else begin
                            state_d = StIdle;
                            ser_d   = 1'b1;
                        end
                    end else begin
                        baud_cnt_d = baud_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    ser_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge MHz10) begin
        if (rst) begin
            state_q     <= StIdle;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            cur_q       <= '0;
            nxt0_q      <= '0;
            nxt1_q      <= '0;
            left_q      <= '0;
            cur_is_st_q <= 1'b0;
            rs_q        <= '0;
            rs_vld_q    <= 1'b0;
            ser_q       <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            cur_q       <= cur_d;
            nxt0_q      <= nxt0_d;
            nxt1_q      <= nxt1_d;
            left_q      <= left_d;
            cur_is_st_q <= cur_is_st_d;
            rs_q        <= rs_d;
            rs_vld_q    <= rs_vld_d;
            ser_q       <= ser_d;
            err_q       <= err_d;
        end
    end

    assign serOut = ser_q;
    assign busy   = (state_q != StIdle) && !rst;
    // done is suppressed when the final stop bit is cut short by an abort.
    assign done   = (state_q == StStop) && baud_end && (left_q == 2'd0) && en && !clear && !rst;
    assign err    = err_q;

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx at BAUD_DIV=4: an expected-byte queue is filled as each request
// is driven and drained while decoding the captured serial line.
module tb_midi_tx;

    localparam int unsigned B = 4;

    logic       MHz10 = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       clear = 1'b0;
    logic       send_r = 1'b0;
    logic       send_n = 1'b0;
    logic [7:0] status = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic [7:0] data2 = 8'h00;
    logic       ser_r, busy_r, done_r, err_r;
    logic       ser_n, busy_n, done_n, err_n;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] q_exp[$];
    logic       rs_valid[2];
    logic [7:0] rs_val[2];

    always #5 MHz10 = ~MHz10;

    midi_tx #(.BAUD_DIV(B), .RUNNING_STATUS(1'b1)) dut_rs (
        .MHz10 (MHz10),
        .rst   (rst),
        .en    (en),
        .clear (clear),
        .send  (send_r),
        .status(status),
        .data1 (data1),
        .data2 (data2),
        .serOut(ser_r),
        .busy  (busy_r),
        .done  (done_r),
        .err   (err_r)
    );

    midi_tx #(.BAUD_DIV(B), .RUNNING_STATUS(1'b0)) dut_nrs (
        .MHz10 (MHz10),
        .rst   (rst),
        .en    (en),
        .clear (clear),
        .send  (send_n),
        .status(status),
        .data1 (data1),
        .data2 (data2),
        .serOut(ser_n),
        .busy  (busy_n),
        .done  (done_n),
        .err   (err_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request (sel 0 = running-status DUT, 1 = plain DUT) and check the whole frame.
    // poke_at >= 0 pulses send with different bytes at that cycle of the message.
    task automatic run_msg(input int sel, input logic [7:0] st, input logic [7:0] d1,
                           input logic [7:0] d2, input int poke_at);
        logic       smp[$];
        logic       two, skip, v, want;
        logic [7:0] exp_b, rx;
        int         nb, exp_cycles, dn_cnt, dn_idx, ferr, idx;

        two  = (st[7:4] == 4'hC) || (st[7:4] == 4'hD);
        skip = (sel == 0) && rs_valid[sel] && (rs_val[sel] == st);
        nb   = 0;
        if (!skip) begin
            q_exp.push_back(st);
            nb++;
        end
        q_exp.push_back({1'b0, d1[6:0]});
        nb++;
        if (!two) begin
            q_exp.push_back({1'b0, d2[6:0]});
            nb++;
        end
        exp_cycles = nb * 10 * B;
        rs_valid[sel] = 1'b1;
        rs_val[sel]   = st;

        status = st;
        data1  = d1;
        data2  = d2;
        if (sel == 1) send_n = 1'b1;
        else send_r = 1'b1;
        @(posedge MHz10);
        #1;
        send_r = 1'b0;
        send_n = 1'b0;

        dn_cnt = 0;
        dn_idx = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge MHz10);
            if (!(sel == 1 ? busy_n : busy_r)) break;
            smp.push_back(sel == 1 ? ser_n : ser_r);
            if (sel == 1 ? done_n : done_r) begin
                dn_cnt++;
                dn_idx = i;
            end
            if (i == poke_at) begin
                status = 8'h90;
                data1  = 8'h11;
                data2  = 8'h22;
                if (sel == 1) send_n = 1'b1;
                else send_r = 1'b1;
            end else begin
                send_r = 1'b0;
                send_n = 1'b0;
            end
        end
        send_r = 1'b0;
        send_n = 1'b0;

        chk("busy_cycles", smp.size(), exp_cycles);
        chk("done_count", dn_cnt, 1);
        chk("done_pos", dn_idx, exp_cycles - 1);
        chk("idle_line", sel == 1 ? ser_n : ser_r, 1'b1);

        for (int k = 0; k < nb; k++) begin
            exp_b = q_exp.pop_front();
            rx    = 8'h00;
            ferr  = 0;
            for (int j = 0; j < 10; j++) begin
                for (int c = 0; c < int'(B); c++) begin
                    idx  = k * 10 * B + j * B + c;
                    v    = (idx < smp.size()) ? smp[idx] : 1'bx;
                    want = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_b[j-1];
                    if (v !== want) ferr++;
                    if (c == 0 && j >= 1 && j <= 8) rx[j-1] = v;
                end
            end
            chk("frame_bits", ferr, 0);
            chk("rx_byte", rx, exp_b);
        end
    endtask

    initial begin
        logic [7:0] rej[2];
        int         dn;
        rej[0] = 8'h3C;
        rej[1] = 8'hF8;
        rs_valid[0] = 1'b0;
        rs_valid[1] = 1'b0;
        rs_val[0]   = 8'h00;
        rs_val[1]   = 8'h00;

        repeat (3) @(negedge MHz10);
        chk("rst_ser", ser_r, 1'b1);
        chk("rst_busy", busy_r, 1'b0);
        chk("rst_done", done_r, 1'b0);
        chk("rst_err", err_r, 1'b0);
        rst = 1'b0;
        @(negedge MHz10);

        // Note-on, then running status right after done, then program change.
        run_msg(0, 8'h90, 8'h3C, 8'h64, -1);
        run_msg(0, 8'h90, 8'h40, 8'h50, -1);
        run_msg(0, 8'hC2, 8'h85, 8'h33, -1);

        for (int r = 0; r < 2; r++) begin
            @(negedge MHz10);
            status = rej[r];
            send_r = 1'b1;
            @(posedge MHz10);
            #1;
            send_r = 1'b0;
            @(negedge MHz10);
            chk("rej_err", err_r, 1'b1);
            chk("rej_busy", busy_r, 1'b0);
            chk("rej_ser", ser_r, 1'b1);
            @(negedge MHz10);
            chk("rej_err_pulse", err_r, 1'b0);
            chk("rej_busy2", busy_r, 1'b0);
        end

        // Abort in the middle of the data1 byte.
        status = 8'h90;
        data1  = 8'h3C;
        data2  = 8'h64;
        send_r = 1'b1;
        @(posedge MHz10);
        #1;
        send_r = 1'b0;
        repeat (48) @(negedge MHz10);
        chk("abort_pre_busy", busy_r, 1'b1);
        clear = 1'b1;
        @(negedge MHz10);
        chk("abort_ser", ser_r, 1'b1);
        chk("abort_busy", busy_r, 1'b0);
        clear = 1'b0;
        dn = 0;
        repeat (10) begin
            @(negedge MHz10);
            if (done_r) dn++;
        end
        chk("abort_no_done", dn, 0);
        rs_valid[0] = 1'b0;
        run_msg(0, 8'h90, 8'h40, 8'h50, -1);

        // send pulsed mid-message must not disturb it.
        run_msg(0, 8'hB0, 8'h07, 8'h7F, 50);

        // Reset during the stop bit of data1, after the status byte has completed.
        @(negedge MHz10);
        status = 8'h91;
        data1  = 8'h01;
        data2  = 8'h02;
        send_r = 1'b1;
        @(posedge MHz10);
        #1;
        send_r = 1'b0;
        repeat (78) @(negedge MHz10);
        chk("rst_mid_busy_pre", busy_r, 1'b1);
        rst = 1'b1;
        @(negedge MHz10);
        chk("rst_mid_ser", ser_r, 1'b1);
        chk("rst_mid_busy", busy_r, 1'b0);
        chk("rst_mid_done", done_r, 1'b0);
        chk("rst_mid_err", err_r, 1'b0);
        @(negedge MHz10);
        rst = 1'b0;
        rs_valid[0] = 1'b0;
        @(negedge MHz10);
        run_msg(0, 8'h91, 8'h01, 8'h02, -1);

        // Running status disabled: repeated status still goes out.
        @(negedge MHz10);
        run_msg(1, 8'h90, 8'h3C, 8'h64, -1);
        run_msg(1, 8'h90, 8'h40, 8'h50, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/midi_tx.md
MIDI_TX -- requirements
Module: midi_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 320, meaning clock cycles per bit (10 MHz / 31250 baud).
REQ-002 SHALL have parameter RUNNING_STATUS, default 1, meaning omit a repeated status byte when 1.
REQ-003 SHALL have port MHz10, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset: synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit, block enable; low means the block is disabled.
REQ-006 SHALL have port clear, input, 1 bit, synchronous abort and running-status flush.
REQ-007 SHALL have port send, input, 1 bit, a one-message transmit request.
REQ-008 SHALL have port status, input, 8 bits, the MIDI status byte.
REQ-009 SHALL have port data1, input, 8 bits, the first data byte (note or controller).
REQ-010 SHALL have port data2, input, 8 bits, the second data byte (velocity or value).
REQ-011 SHALL have port serOut, output, 1 bit, the UART line; idle high.
REQ-012 SHALL have port busy, output, 1 bit, high while a message is in flight.
REQ-013 SHALL have port done, output, 1 bit, one-cycle pulse when a message completes.
REQ-014 SHALL have port err, output, 1 bit, one-cycle pulse when a request is rejected.

Function
REQ-015 SHALL accept a request only on a cycle with send=1, busy=0, en=1, clear=0, rst=0.
- On acceptance, latch status, data1 and data2.
- Assert busy from the next cycle.
- Ignore send while busy=1 (no queueing, no err).
REQ-016 SHALL derive the message length from status[7:4]:
- 0x8, 0x9, 0xA, 0xB, 0xE -> 3 bytes.
- 0xC, 0xD -> 2 bytes.
REQ-017 SHALL reject a request with status[7]=0 or status[7:4]=0xF:
- Pulse err for one cycle, the cycle after the request.
- Leave busy=0 and serOut=1.
REQ-018 SHALL, when RUNNING_STATUS=1 and the accepted status equals the last transmitted status, skip the status byte and send only the data bytes.
REQ-019 SHALL send the data bytes with bit 7 forced to 0.
REQ-020 SHALL use a state machine with states IDLE, START, DATA, STOP.
- IDLE -> START on acceptance.
- START -> DATA after BAUD_DIV cycles.
- DATA -> STOP after 8 bits, each BAUD_DIV cycles.
- STOP -> START if bytes remain; otherwise -> IDLE.
REQ-021 SHALL frame every byte as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each held exactly BAUD_DIV cycles.
REQ-022 SHALL drive serOut low in the first cycle after acceptance (1-cycle latency).
- serOut SHALL be registered and glitch-free.
REQ-023 SHALL send consecutive bytes of one message back-to-back with no idle gap between a stop bit and the next start bit.
REQ-024 SHALL pulse done on the last cycle of the final stop bit.
- busy SHALL fall on the following cycle.
- A new send SHALL be acceptable in that same following cycle.
REQ-025 SHALL update the running-status register only when a status byte's stop bit completes.
REQ-026 SHALL, on en=0 or clear=1 at any time:
- Return to IDLE in the next cycle.
- Drive serOut=1 and busy=0.
- Issue no done.
- Invalidate the running-status register.
REQ-027 SHALL give a complete 3-byte message a duration of 30*BAUD_DIV cycles and a 2-byte message 20*BAUD_DIV cycles.

Reset
REQ-028 SHALL, while rst=1, hold the state machine in IDLE.
REQ-029 SHALL, while rst=1, force serOut=1, busy=0, done=0, err=0.
REQ-030 SHALL, while rst=1, clear all counters and latched bytes.
REQ-031 SHALL, while rst=1, invalidate the running-status register.
REQ-032 SHALL give rst priority over en, clear and send.
REQ-033 SHALL, when rst is asserted mid-frame, abort the frame with serOut=1 on the next edge.

Verification
REQ-034 SHALL cover note-on: send with 0x90/0x3C/0x64 from idle, BAUD_DIV=4.
- serOut carries bytes 0x90, 0x3C, 0x64 framed, 120 cycles total.
- done pulses once; busy is high for exactly 120 cycles.
REQ-035 SHALL cover running status: a second request 0x90/0x40/0x50 right after done.
- Only 0x40 and 0x50 are sent, 80 cycles.
- Repeat with RUNNING_STATUS=0: 3 bytes, 120 cycles.
REQ-036 SHALL cover a 2-byte message: program change 0xC2/0x85/xx.
- Bytes 0xC2 then 0x05 are sent, 80 cycles at BAUD_DIV=4.
REQ-037 SHALL cover rejection: send with status 0x3C, then with status 0xF8.
- err pulses 1 cycle each; busy stays 0; serOut stays 1.
REQ-038 SHALL cover abort: clear=1 in the middle of data1.
- serOut=1 and busy=0 on the next cycle; no done.
- A following 0x90 request re-sends the status byte.
REQ-039 SHALL cover busy and reset: send pulsed while busy is ignored, and the message is unchanged; rst=1 mid-stop-bit drives all outputs to reset values on the next edge.
